// File: rtl/valid_shift_pipe.sv
// Fixed-latency metadata pipe with per-stage valid, flush and (SHIFT_PIPE_MASK_KILL_EN) branch-mask kill/clear.
// Latency: exactly DEPTH cycles per unstalled shift; each stall cycle adds one.
// Backpressure: stall_in freezes every stage; ready_out = ~stall_in; no consumer handshake at the output.
module valid_shift_pipe #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MASK_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [WIDTH-1:0]             pipe_in,
  input  logic                         stall_in,
  input  logic                         flush_in,
`ifdef SHIFT_PIPE_MASK_KILL_EN
  input  logic [MASK_WIDTH-1:0]        mask_in,
  input  logic                         kill_in,
  input  logic [MASK_WIDTH-1:0]        kill_mask,
  input  logic                         clear_in,
  input  logic [MASK_WIDTH-1:0]        clear_mask,
  output logic [MASK_WIDTH-1:0]        mask_out,
`endif
  output logic                         ready_out,
  output logic                         valid_out,
  output logic [WIDTH-1:0]             pipe_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         busy_out
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (WIDTH < 1 || DEPTH < 1 || MASK_WIDTH < 1) begin : g_bad_param
    $error("valid_shift_pipe: WIDTH, DEPTH and MASK_WIDTH must all be >= 1");
  end

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [CW-1:0]               count_q, count_d;
  logic [DEPTH-1:0]            kill_hit;
  logic                        in_kill;
  logic [CW-1:0]               kill_cnt;

`ifdef SHIFT_PIPE_MASK_KILL_EN
  logic [DEPTH-1:0][MASK_WIDTH-1:0] msk_q, msk_d;
  logic [MASK_WIDTH-1:0]            clr;

  // Kill looks at pre-clear masks, so a same-cycle clear cannot rescue an entry.
  always_comb begin
    clr     = clear_in ? clear_mask : '0;
    in_kill = kill_in && (|(mask_in & kill_mask));
    for (int k = 0; k < int'(DEPTH); k++) begin
      kill_hit[k] = kill_in && vld_q[k] && (|(msk_q[k] & kill_mask));
    end
  end
`else
  assign kill_hit = '0;
  assign in_kill  = 1'b0;
`endif

  // A killed entry in the last stage leaves anyway on a shift; count it only once.
  always_comb begin
    kill_cnt = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (kill_hit[k] && (stall_in || k != int'(DEPTH) - 1)) begin
        kill_cnt = kill_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    vld_d   = vld_q;
    dat_d   = dat_q;
    count_d = count_q;
`ifdef SHIFT_PIPE_MASK_KILL_EN
    msk_d   = msk_q;
`endif
    if (flush_in) begin
      vld_d   = '0;
      count_d = '0;
    end else if (stall_in) begin
      vld_d   = vld_q & ~kill_hit;
      count_d = count_q - kill_cnt;
`ifdef SHIFT_PIPE_MASK_KILL_EN
      for (int k = 0; k < int'(DEPTH); k++) begin
        msk_d[k] = msk_q[k] & ~clr;
      end
`endif
    end else begin
      vld_d[0] = valid_in & ~in_kill;
      dat_d[0] = pipe_in;
      for (int k = 1; k < int'(DEPTH); k++) begin
        vld_d[k] = vld_q[k-1] & ~kill_hit[k-1];
        dat_d[k] = dat_q[k-1];
      end
      count_d = count_q + CW'(valid_in & ~in_kill) - CW'(vld_q[DEPTH-1]) - kill_cnt;
`ifdef SHIFT_PIPE_MASK_KILL_EN
      msk_d[0] = mask_in & ~clr;
      for (int k = 1; k < int'(DEPTH); k++) begin
        msk_d[k] = msk_q[k-1] & ~clr;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      dat_q   <= '0;
      count_q <= '0;
`ifdef SHIFT_PIPE_MASK_KILL_EN
      msk_q   <= '0;
`endif
    end else begin
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      count_q <= count_d;
`ifdef SHIFT_PIPE_MASK_KILL_EN
      msk_q   <= msk_d;
`endif
    end
  end

  assign ready_out = ~stall_in;
  assign valid_out = vld_q[DEPTH-1];
  assign pipe_out  = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;
  assign count_out = count_q;
  assign busy_out  = (count_q != '0);
`ifdef SHIFT_PIPE_MASK_KILL_EN
  assign mask_out  = vld_q[DEPTH-1] ? msk_q[DEPTH-1] : '0;
`endif

endmodule

// File: tb/tb_valid_shift_pipe.sv
// Bench for valid_shift_pipe: directed scenarios then random traffic against an age-queue model.
module tb_valid_shift_pipe;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int MW    = 4;

  logic             clk = 1'b0;
  logic             rst_n, valid_in, stall_in, flush_in;
  logic [WIDTH-1:0] pipe_in;
  logic             ready_out, valid_out, busy_out;
  logic [WIDTH-1:0] pipe_out;
  logic [2:0]       count_out;
`ifdef SHIFT_PIPE_MASK_KILL_EN
  logic [MW-1:0]    mask_in = '0, kill_mask = '0, clear_mask = '0, mask_out;
  logic             kill_in = 1'b0, clear_in = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  valid_shift_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MASK_WIDTH(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .pipe_in   (pipe_in),
    .stall_in  (stall_in),
    .flush_in  (flush_in),
`ifdef SHIFT_PIPE_MASK_KILL_EN
    .mask_in   (mask_in),
    .kill_in   (kill_in),
    .kill_mask (kill_mask),
    .clear_in  (clear_in),
    .clear_mask(clear_mask),
    .mask_out  (mask_out),
`endif
    .ready_out (ready_out),
    .valid_out (valid_out),
    .pipe_out  (pipe_out),
    .count_out (count_out),
    .busy_out  (busy_out)
  );

  always #5 clk = ~clk;

  // Model: in-flight entries oldest first, each with the number of unstalled edges left before it is at the output.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               rem;
  } ent_t;
  ent_t mq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d,
                      input logic st, input logic fl);
    logic             ev;
    logic [WIDTH-1:0] ed;
    rst_n    = r;
    valid_in = v;
    pipe_in  = d;
    stall_in = st;
    flush_in = fl;
    #1;
    chk("ready_out", {31'd0, ready_out}, {31'd0, ~st});
    @(posedge clk);
    if (!r || fl) begin
      mq.delete();
    end else if (!st) begin
      if (mq.size() > 0 && mq[0].rem == 0) void'(mq.pop_front());
      foreach (mq[i]) mq[i].rem--;
      if (v) mq.push_back('{d: d, rem: DEPTH - 1});
    end
    #1;
    ev = (mq.size() > 0) && (mq[0].rem == 0);
    ed = ev ? mq[0].d : '0;
    chk("valid_out", {31'd0, valid_out}, {31'd0, ev});
    chk("pipe_out",  {24'd0, pipe_out},  {24'd0, ed});
    chk("count_out", {29'd0, count_out}, mq.size());
    chk("busy_out",  {31'd0, busy_out},  {31'd0, mq.size() != 0});
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);

    // Three back-to-back entries, then drain
    step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
    chk("peak_count", {29'd0, count_out}, 32'd3);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);

    // Alternating bubbles
    for (int i = 0; i < 8; i++) step(1'b1, 1'(i % 2 == 0), 8'hA0 + 8'(i / 2), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Stall with a junk entry offered
    step(1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("no_ff_out", {31'd0, pipe_out == 8'hFF}, 32'd0);
    end

    // Full pipe flushed alongside a new entry
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
    chk("flush_count", {29'd0, count_out}, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-stream while stalled, then a fresh entry
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h7F, 1'b1, 1'b0);
    chk("rst_count", {29'd0, count_out}, 32'd0);
    step(1'b1, 1'b1, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

`ifdef SHIFT_PIPE_MASK_KILL_EN
    // Kill and clear on the same edge
    mask_in = 4'b0001; step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    mask_in = 4'b0010; step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    mask_in = 4'b0011; step(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    mask_in = 4'b0000;
    valid_in = 1'b0; kill_in = 1'b1; kill_mask = 4'b0010; clear_in = 1'b1; clear_mask = 4'b0001;
    @(posedge clk);
    #1;
    kill_in = 1'b0; clear_in = 1'b0;
    chk("kill_count", {29'd0, count_out}, 32'd1);
    chk("kill_valid", {31'd0, valid_out}, 32'd1);
    chk("kill_data",  {24'd0, pipe_out}, 32'h01);
    chk("kill_mask",  {28'd0, mask_out}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/valid_shift_pipe.md
# valid_shift_pipe

Parametrised fixed-latency delay pipe with per-stage valid tracking, global stall, flush, and optional selective kill by branch mask. Execution lanes use it to carry result metadata (destination tag, writeback enable) alongside multi-cycle functional units. It shifts every unstalled cycle, bubbles included, so latency is exactly DEPTH cycles regardless of input valid.

## Interface
- WIDTH, 8, payload bits per stage (≥1)
- DEPTH, 4, number of stages and latency in cycles (≥1)
- MASK_WIDTH, 4, branch-mask bits per entry (used only with SHIFT_PIPE_MASK_KILL_EN)

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- valid_in  input  1  payload at pipe_in is a real entry
- pipe_in  input  WIDTH  payload
- stall_in  input  1  hold all stages; valid_in ignored this cycle
- flush_in  input  1  invalidate every entry, including the incoming one
- ready_out  output  1  combinational ~stall_in; upstream presents entries only when high
- valid_out  output  1  stage DEPTH-1 holds a live entry
- pipe_out  output  WIDTH  stage DEPTH-1 payload, forced to 0 when valid_out=0
- count_out  output  $clog2(DEPTH+1)  number of live entries, registered
- busy_out  output  1  count_out != 0
- mask_in / kill_in / kill_mask / clear_in / clear_mask / mask_out (macro only): MASK_WIDTH-wide entry mask input, kill strobe plus mask, resolve strobe plus mask, stage DEPTH-1 mask output (0 when invalid)

## Operation
- Storage: DEPTH stages of {valid, payload[, mask]}; stage 0 loads from the inputs, stage k loads from stage k-1.
- Reset (rst_n=0 at an edge): all valid, payload, mask bits cleared. valid_out=0, pipe_out=0, count_out=0, busy_out=0, mask_out=0.
- Priority per edge: reset > flush > stall > shift.
- Flush: all valid bits clear on the next edge, including stalled entries. Incoming entry dropped. Payload bits need not clear.
- Stall without flush: all stages hold. valid_in is not captured. Kill and clear still apply to held entries (macro).
- Shift: stage 0 <= {valid_in, pipe_in}; each stage takes its predecessor; stage DEPTH-1 leaves. There is no consumer handshake; the output is valid for exactly one unstalled cycle.
- count_out next = live entries after the update. It is computed incrementally: +1 for entering, -1 for leaving, minus killed entries. It is never popcounted from stale state and never exceeds DEPTH.

## Timing
- Unstalled latency: entry sampled at edge N appears at valid_out after edge N+DEPTH-1, visible in cycle N+DEPTH-1..N+DEPTH. This is DEPTH registers.
- Each stall cycle adds one cycle of latency to every in-flight entry.
- Outputs are registered except ready_out. Gating of pipe_out/mask_out by valid is combinational from registers.
- DEPTH=1: single register stage; count_out is 1 bit.

## Configuration
- SHIFT_PIPE_MASK_KILL_EN defined: mask ports and per-stage MASK_WIDTH mask exist.
  - kill_in kills every entry (stored and incoming) with mask & kill_mask != 0. This applies on the same edge, including under stall.
  - clear_in clears the clear_mask bits from every stored and incoming mask.
  - Kill and clear in the same cycle: kill is evaluated on pre-clear masks.
  - flush_in still kills all.
- Undefined: no mask storage or ports. Only flush_in invalidates entries.

## Test plan
- Reset then DEPTH=4: valid_in=1 with pipe_in=0x11,0x22,0x33 on consecutive edges -> valid_out high for 3 cycles starting 3 cycles after first capture, emitting 0x11,0x22,0x33. count_out peaks at 3 and returns to 0.
- Alternate valid_in 1/0 with payloads 0xA0..0xA3 -> output shows the same bubble pattern delayed by DEPTH. pipe_out=0 in bubble cycles.
- Load 2 entries, assert stall_in 3 cycles with valid_in=1 and pipe_in=0xFF -> 0xFF is never emitted, latency of held entries grows by 3, ready_out=0 during the stall.
- Pipe holding 4 live entries with flush_in plus valid_in in the same cycle -> next cycle count_out=0 and busy_out=0. No valid_out for the following DEPTH cycles.
- rst_n low mid-stream with 3 live entries and stall_in=1 -> all outputs 0 after the edge. A new entry after reset emerges with normal latency.
- Macro on, MASK_WIDTH=4: entries carry masks 0001, 0010, 0011. kill_in with kill_mask=0010 plus clear_in with clear_mask=0001 on the same edge -> only the first entry survives, its mask_out=0000, and count_out drops from 3 to 1.
